power_on_reset_gen: RTL and testbench

//  Power-on and external reset generator for FPGA designs that have no dedicated reset pin.

---
 rtl/rst_gen_pkg.sv | 11 +
 rtl/sync_2ff.sv | 20 ++
 rtl/power_on_reset_gen.sv | 84 ++++++++
 tb/tb_power_on_reset_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rst_gen_pkg.sv
// Shared types and helpers for the power-on reset generator.
package rst_gen_pkg;

  typedef enum logic [0:0] {HOLD, RUN} state_e;

  // Bits needed to hold a count from 0 up to and including n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single bit, with configuration-time initial value.
module sync_2ff #(
  parameter logic InitVal = 1'b0
) (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q = InitVal;
  logic sync_q = InitVal;

  always_ff @(posedge clk_i) begin
    meta_q <= d_i;
    sync_q <= meta_q;
  end

  assign q_o = sync_q;

endmodule

// File: rtl/power_on_reset_gen.sv
// Power-on / external reset stretcher driven entirely from configuration-time register values.
// Define RST_GEN_SYNC_EN to pass rst_n_i through a 2-flop synchroniser first.
module power_on_reset_gen
  import rst_gen_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic rst_o,
  output logic rst_n_o,
  output logic por_done_o
);

  localparam int unsigned CW = cnt_width(RST_CYCLES);
  localparam logic [CW-1:0] CntTarget = CW'(RST_CYCLES);
  localparam logic [CW-1:0] CntLast   = CW'(RST_CYCLES - 1);

  logic req_n;

`ifdef RST_GEN_SYNC_EN
  sync_2ff #(
    .InitVal(1'b0)
  ) u_sync (
    .clk_i(clk_i),
    .d_i  (rst_n_i),
    .q_o  (req_n)
  );
`else
  assign req_n = rst_n_i;
`endif

  // Initial values model FPGA configuration state: reset is asserted before any clock edge.
  state_e        state_q    = HOLD;
  state_e        state_d;
  logic [CW-1:0] cnt_q      = '0;
  logic [CW-1:0] cnt_d;
  logic          rst_q      = 1'b1;
  logic          rst_d;
  logic          por_done_q = 1'b0;
  logic          por_done_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rst_d      = rst_q;
    por_done_d = por_done_q;
    unique case (state_q)
      HOLD: begin
        rst_d = 1'b1;
        if (cnt_q != CntTarget) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (cnt_q == CntLast) begin
          state_d    = RUN;
          rst_d      = 1'b0;
          por_done_d = 1'b1;
        end
      end
      RUN: begin
        rst_d = 1'b0;
      end
    endcase
  end

  // External request wins over counting; por_done is untouched by it.
  always_ff @(posedge clk_i) begin
    if (!req_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_q      <= rst_d;
      por_done_q <= por_done_d;
    end
  end

  assign rst_o      = rst_q;
  assign rst_n_o    = ~rst_q;
  assign por_done_o = por_done_q;

endmodule

// File: tb/tb_power_on_reset_gen.sv
// Bench for power_on_reset_gen: run-length model checked every cycle plus literal timing checks.
module tb_power_on_reset_gen;

`ifdef RST_GEN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic one = 1'b1;

  logic a_rst, a_rst_n, a_done;
  logic b_rst, b_rst_n, b_done;
  logic c_rst, c_rst_n, c_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // a: rst_n_i tied high from configuration; b: driven, 16 cycles; c: driven, 1 cycle.
  power_on_reset_gen #(.RST_CYCLES(16)) dut_a (
    .clk_i(clk), .rst_n_i(one), .rst_o(a_rst), .rst_n_o(a_rst_n), .por_done_o(a_done)
  );
  power_on_reset_gen #(.RST_CYCLES(16)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .rst_o(b_rst), .rst_n_o(b_rst_n), .por_done_o(b_done)
  );
  power_on_reset_gen #(.RST_CYCLES(1)) dut_c (
    .clk_i(clk), .rst_n_i(rst_n), .rst_o(c_rst), .rst_n_o(c_rst_n), .por_done_o(c_done)
  );

  task automatic check(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: reset is released once RST_CYCLES consecutive high samples have been seen.
  int ncyc[3] = '{16, 16, 1};
  int run_len[3] = '{0, 0, 0};
  bit done_m[3] = '{0, 0, 0};
  bit dly1[3] = '{0, 0, 0};
  bit dly2[3] = '{0, 0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit s;
      bit eff;
      s = (i == 0) ? 1'b1 : rst_n;
      if (LAT == 2) begin
        eff = dly2[i];
        dly2[i] = dly1[i];
        dly1[i] = s;
      end else begin
        eff = s;
      end
      if (!eff) run_len[i] = 0;
      else if (run_len[i] < 1000000) run_len[i]++;
      if (run_len[i] >= ncyc[i]) done_m[i] = 1'b1;
    end
  end

  function automatic logic exp_rst(input int i);
    return (run_len[i] < ncyc[i]);
  endfunction

  always @(negedge clk) begin
    check("a_rst_o", a_rst, exp_rst(0));
    check("a_rst_n_o", a_rst_n, ~exp_rst(0));
    check("a_por_done_o", a_done, done_m[0]);
    check("b_rst_o", b_rst, exp_rst(1));
    check("b_rst_n_o", b_rst_n, ~exp_rst(1));
    check("b_por_done_o", b_done, done_m[1]);
    check("c_rst_o", c_rst, exp_rst(2));
    check("c_rst_n_o", c_rst_n, ~exp_rst(2));
    check("c_por_done_o", c_done, done_m[2]);
  end

  // Counts edges until dut_b's rst_o reads 0; bounded.
  task automatic wait_fall_b(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (b_rst == 1'b0) break;
    end
  endtask

  task automatic check_int(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  int n;

  initial begin
    // Configuration state before any edge
    #1;
    check("t0_a_rst_o", a_rst, 1'b1);
    check("t0_a_rst_n_o", a_rst_n, 1'b0);
    check("t0_a_done", a_done, 1'b0);
    check("t0_b_rst_o", b_rst, 1'b1);
    check("t0_c_rst_o", c_rst, 1'b1);

    // Power-up stretch on dut_a (rst_n_i tied high)
    repeat (16 + LAT - 1) @(posedge clk);
    @(negedge clk);
    check("pu_a_high_edge_last_minus1", a_rst, 1'b1);
    check("pu_a_done_still_0", a_done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("pu_a_low_after_last", a_rst, 1'b0);
    check("pu_a_rst_n_o_high", a_rst_n, 1'b1);
    check("pu_a_done_set", a_done, 1'b1);

    // Held low for ~1000 cycles before first release
    repeat (1000 - (16 + LAT)) @(posedge clk);
    @(negedge clk);
    check("hold_b_rst_o", b_rst, 1'b1);
    check("hold_b_done", b_done, 1'b0);
    check("hold_c_rst_o", c_rst, 1'b1);
    check("hold_c_done", c_done, 1'b0);
    rst_n = 1'b1;

    // RST_CYCLES=1 falls after first high edge; dut_b after 16
    repeat (1 + LAT) @(posedge clk);
    @(negedge clk);
    check("c_fall_first_edge", c_rst, 1'b0);
    check("c_done_first_edge", c_done, 1'b1);
    check("b_still_high", b_rst, 1'b1);
    wait_fall_b(n);
    check_int("b_release_stretch", n + 1 + LAT, 16 + LAT);

    // External reset in RUN for 3 edges
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1 + LAT) begin
        check("ext_assert_latency", b_rst, 1'b1);
        check("ext_done_sticky", b_done, 1'b1);
      end else if (k < 1 + LAT) begin
        check("ext_not_yet", b_rst, 1'b0);
      end
    end
    rst_n = 1'b1;
    wait_fall_b(n);
    check_int("ext_release_stretch", n, 16 + LAT);

    // Glitch mid-HOLD: stretch restarts in full
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fall_b(n);
    check_int("glitch_full_stretch", n, 16 + LAT);
    check("glitch_done_sticky", b_done, 1'b1);

    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
